// File: rtl/frame_scheduler_pkg.sv
// Shared data-frames package: payload type, scheduler state encoding,
// frame source identifiers and the round-robin pointer helper.
package frame_scheduler_pkg;

  localparam int PAYLOAD_BITS = 16;
  typedef logic [PAYLOAD_BITS-1:0] payload_t;

  // Source ids cover every requester plus one extra code for heartbeats.
  localparam int DEFAULT_N_PORTS = 3;
  localparam int SRC_ID_W        = $clog2(DEFAULT_N_PORTS + 1);
  typedef logic [SRC_ID_W-1:0] src_id_t;
  localparam src_id_t HEARTBEAT_SRC = src_id_t'(DEFAULT_N_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } sched_state_t;

  // Next round-robin start after serving port k (k >= 1); port 0 never
  // takes part in the rotation, so the wrap lands on port 1.
  function automatic int unsigned rr_next(input int unsigned port,
                                          input int unsigned n_ports);
    return (port + 1 >= n_ports) ? 1 : port + 1;
  endfunction

endpackage

// File: rtl/frame_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr, runs up
// to the top port and then wraps to port 0. Grant is one-hot or zero.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic [31:0] start;
  logic        found;

  // Two passes: ports at or above the pointer first, then the wrapped range.
  always_comb begin
    grant = '0;
    found = 1'b0;
    start = 32'(ptr);
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && j >= start && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && j < start && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: picks one requester (port 0 strict priority, the rest
// round-robin) or an idle heartbeat, offers the frame to the payload
// transmitter and holds the payload steady until the transmitter is done.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int N_PORTS         = 3,
  parameter int PAYLOAD_W       = $bits(payload_t),
  parameter int HEARTBEAT_TICKS = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_PORTS-1:0]             req_valid,
  output logic [N_PORTS-1:0]             req_ready,
  input  logic [N_PORTS*PAYLOAD_W-1:0]   req_payload,
  input  logic [PAYLOAD_W-1:0]           heartbeat_payload,
  input  logic                           output_tick,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [PAYLOAD_W-1:0]           tx_payload,
  output logic [$clog2(N_PORTS+1)-1:0]   tx_src,
  output logic                           tx_done
);

  localparam int SRC_W = $clog2(N_PORTS + 1);
  localparam int PTR_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(HEARTBEAT_TICKS + 1);

  sched_state_t         state, state_n;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]     idle_cnt, idle_cnt_n;
  logic                 tx_valid_n, tx_done_n;
  logic [PAYLOAD_W-1:0] tx_payload_n;
  logic [SRC_W-1:0]     tx_src_n;

  logic [N_PORTS-1:0]   rr_req, rr_grant, grant;
  logic                 grant_en;

  // Port 0 is excluded from the rotation; it is handled by strict priority.
  assign rr_req = {req_valid[N_PORTS-1:1], 1'b0};

  rr_arbiter #(.N(N_PORTS)) u_rr_arbiter (
    .req   (rr_req),
    .ptr   (rr_ptr),
    .grant (rr_grant)
  );

  assign req_ready = grant;

  // Next-state, grant and datapath selection; registered values held by default.
  always_comb begin
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    idle_cnt_n   = idle_cnt;
    tx_valid_n   = tx_valid;
    tx_done_n    = 1'b0;
    tx_payload_n = tx_payload;
    tx_src_n     = tx_src;

    // The tx_done cycle is a mandatory gap before the next grant.
    grant_en = (state == ST_IDLE) && !tx_done && !reset;
    grant    = '0;
    if (grant_en) begin
      grant = req_valid[0] ? N_PORTS'(1) : rr_grant;
    end

    unique case (state)
      ST_IDLE: begin
        if (output_tick && idle_cnt != CNT_W'(HEARTBEAT_TICKS)) begin
          idle_cnt_n = idle_cnt + CNT_W'(1);
        end
        if (|grant) begin
          for (int unsigned j = 0; j < N_PORTS; j++) begin
            if (grant[j]) begin
              tx_payload_n = req_payload[j*PAYLOAD_W +: PAYLOAD_W];
              tx_src_n     = SRC_W'(j);
              if (j != 0) begin
                rr_ptr_n = PTR_W'(rr_next(j, N_PORTS));
              end
            end
          end
          tx_valid_n = 1'b1;
          idle_cnt_n = '0;
          state_n    = ST_OFFER;
        end else if (grant_en && idle_cnt == CNT_W'(HEARTBEAT_TICKS)) begin
          tx_payload_n = heartbeat_payload;
          tx_src_n     = SRC_W'(N_PORTS);
          tx_valid_n   = 1'b1;
          idle_cnt_n   = '0;
          state_n      = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (tx_ready) begin
          tx_done_n = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= PTR_W'(1);
      idle_cnt   <= '0;
      tx_valid   <= 1'b0;
      tx_done    <= 1'b0;
      tx_payload <= '0;
      tx_src     <= '0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      idle_cnt   <= idle_cnt_n;
      tx_valid   <= tx_valid_n;
      tx_done    <= tx_done_n;
      tx_payload <= tx_payload_n;
      tx_src     <= tx_src_n;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus queues the frames it expects,
// a monitor pops and compares on every transmitter handshake.
module tb_frame_scheduler;

  localparam int NP = 3;
  localparam int PW = 16;
  localparam int HB = 8;

  logic            clk, reset;
  logic [NP-1:0]   req_valid, req_ready;
  logic [NP*PW-1:0] req_payload;
  logic [PW-1:0]   heartbeat_payload;
  logic            output_tick;
  logic            tx_valid, tx_ready, tx_done;
  logic [PW-1:0]   tx_payload;
  logic [1:0]      tx_src;

  int vectors     = 0;
  int miscompares = 0;
  int hold_cycles = 0;

  typedef struct {
    int            src;
    logic [PW-1:0] payload;
  } exp_t;
  exp_t exp_q[$];

  frame_scheduler #(
    .N_PORTS         (NP),
    .PAYLOAD_W       (PW),
    .HEARTBEAT_TICKS (HB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_payload       (req_payload),
    .heartbeat_payload (heartbeat_payload),
    .output_tick       (output_tick),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_payload        (tx_payload),
    .tx_src            (tx_src),
    .tx_done           (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [PW-1:0] d);
    req_valid[p]            = v;
    req_payload[p*PW +: PW] = d;
  endtask

  task automatic expect_frame(input int src, input logic [PW-1:0] d);
    exp_t e;
    e.src     = src;
    e.payload = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(output int port);
    port = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        for (int p = 0; p < NP; p++) if (req_ready[p]) port = p;
        @(posedge clk);
        #1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL grant_timeout: no req_ready within 200 cycles at %0t", $time);
  endtask

  // Transmitter model: optionally drops tx_ready for hold_cycles after accept.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && tx_valid && tx_ready && hold_cycles > 0) begin
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (hold_cycles) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  logic [PW-1:0] held_payload;
  logic [1:0]    held_src;
  bit            in_busy    = 1'b0;
  bit            done_due   = 1'b0;
  bit            stable_bad = 1'b0;

  initial begin
    exp_t e;
    logic legal;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_busy  = 1'b0;
        done_due = 1'b0;
      end else begin
        if (tx_done || done_due) check("tx_done", 32'(tx_done), 32'(done_due));
        done_due = 1'b0;
        if (|req_ready) begin
          legal = $onehot(req_ready) && ((req_ready & ~req_valid) == '0)
                  && !tx_valid && !in_busy && !tx_done;
          check("req_ready_legal", 32'(legal), 32'd1);
        end
        if (in_busy) begin
          if (tx_payload != held_payload || tx_src != held_src || tx_valid) stable_bad = 1'b1;
          if (tx_ready) begin
            check("frame_stable", 32'(stable_bad), 32'd0);
            in_busy  = 1'b0;
            done_due = 1'b1;
          end
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: src %0d payload 0x%0h, expected none at %0t",
                     tx_src, tx_payload, $time);
          end else begin
            e = exp_q.pop_front();
            check("tx_src", 32'(tx_src), 32'(e.src));
            check("tx_payload", 32'(tx_payload), 32'(e.payload));
          end
          held_payload = tx_payload;
          held_src     = tx_src;
          stable_bad   = 1'b0;
          in_busy      = 1'b1;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int port;
    reset             = 1'b1;
    req_valid         = '0;
    req_payload       = '0;
    heartbeat_payload = 16'h5EA7;
    output_tick       = 1'b0;
    step(3);
    reset = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_tx_payload", 32'(tx_payload), 32'd0);
    check("rst_tx_src", 32'(tx_src), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    check("rst_idle_cnt", 32'(dut.idle_cnt), 32'd0);

    // Ports 1 and 2 continuously valid: 1,2,1,2.
    set_req(1, 1'b1, 16'hA111);
    set_req(2, 1'b1, 16'hB222);
    expect_frame(1, 16'hA111);
    expect_frame(2, 16'hB222);
    expect_frame(1, 16'hA111);
    expect_frame(2, 16'hB222);
    for (int i = 0; i < 4; i++) begin
      wait_grant(port);
      check("rr_alternate", 32'(port), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    req_valid = '0;
    step(4);

    // Single port-1 frame moves the pointer to 2.
    set_req(1, 1'b1, 16'hC0C1);
    expect_frame(1, 16'hC0C1);
    wait_grant(port);
    req_valid[1] = 1'b0;
    check("p1_grant", 32'(port), 32'd1);
    check("rr_ptr_after_p1", 32'(dut.rr_ptr), 32'd2);
    step(4);

    // Ports 0 and 2 together: port 0 first, pointer untouched, then port 2.
    set_req(0, 1'b1, 16'hD000);
    set_req(2, 1'b1, 16'hE222);
    expect_frame(0, 16'hD000);
    expect_frame(2, 16'hE222);
    wait_grant(port);
    req_valid[0] = 1'b0;
    check("p0_priority", 32'(port), 32'd0);
    check("rr_ptr_after_p0", 32'(dut.rr_ptr), 32'd2);
    wait_grant(port);
    req_valid[2] = 1'b0;
    check("p2_after_p0", 32'(port), 32'd2);
    check("rr_ptr_wrap", 32'(dut.rr_ptr), 32'd1);
    step(4);

    // Heartbeat after the 8th tick, ticks every 4 clocks.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_frame(3, 16'h5EA7);
      output_tick = 1'b1;
      step(1);
      output_tick = 1'b0;
      step(3);
      if (i == 6) begin
        check("no_early_hb", 32'(tx_valid), 32'd0);
        check("idle_cnt_7", 32'(dut.idle_cnt), 32'd7);
      end
    end
    step(6);

    // Slow transmitter; payload input churns while the frame is in flight.
    hold_cycles = 20;
    set_req(1, 1'b1, 16'hF00D);
    expect_frame(1, 16'hF00D);
    wait_grant(port);
    req_valid[1] = 1'b0;
    check("slow_grant", 32'(port), 32'd1);
    for (int c = 0; c < 24; c++) begin
      req_payload[PW +: PW] = 16'h0100 + 16'(c);
      set_req(2, (c >= 3 && c < 7), 16'h2200);
      if (c == 10) check("payload_hold", 32'(tx_payload), 32'h0000F00D);
      step(1);
    end
    hold_cycles = 0;
    step(4);

    // Reset while BUSY abandons the frame.
    hold_cycles = 20;
    set_req(1, 1'b1, 16'h3636);
    expect_frame(1, 16'h3636);
    wait_grant(port);
    req_valid[1] = 1'b0;
    check("busy_grant", 32'(port), 32'd1);
    step(5);
    check("rr_ptr_pre_reset", 32'(dut.rr_ptr), 32'd2);
    reset = 1'b1;
    set_req(2, 1'b1, 16'h2BAD);
    step(1);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_done", 32'(tx_done), 32'd0);
    check("mid_rst_tx_payload", 32'(tx_payload), 32'd0);
    check("mid_rst_tx_src", 32'(tx_src), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    check("mid_rst_idle_cnt", 32'(dut.idle_cnt), 32'd0);
    reset       = 1'b0;
    req_valid   = '0;
    hold_cycles = 0;
    step(30);

    // Request arrives in the cycle idle_cnt sits at the heartbeat threshold.
    for (int i = 0; i < 8; i++) begin
      output_tick = 1'b1;
      step(1);
      output_tick = 1'b0;
      if (i < 7) step(1);
    end
    check("idle_cnt_8", 32'(dut.idle_cnt), 32'd8);
    set_req(1, 1'b1, 16'h3737);
    expect_frame(1, 16'h3737);
    wait_grant(port);
    req_valid[1] = 1'b0;
    check("req_beats_hb", 32'(port), 32'd1);
    check("idle_cnt_cleared", 32'(dut.idle_cnt), 32'd0);
    step(6);

    for (int c = 0; c < 100 && exp_q.size() != 0; c++) step(1);
    step(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter N_PORTS, default 3, number of frame requesters (>=2); port 0 is the timing port.
REQ-002 Parameter PAYLOAD_W, default $bits(payload_t), payload width in bits.
REQ-003 Parameter HEARTBEAT_TICKS, default 1000, idle output ticks before a heartbeat frame is sent.
REQ-004 clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  N_PORTS  per-port frame request.
REQ-006 req_ready  output  N_PORTS  per-port accept; one-hot or zero.
REQ-007 req_payload  input  N_PORTS x PAYLOAD_W  per-port frame payload.
REQ-008 heartbeat_payload  input  PAYLOAD_W  payload used for heartbeat frames.
REQ-009 output_tick  input  1  serializer symbol tick, one clk cycle wide.
REQ-010 tx_valid  output  1  frame offered to the payload transmitter.
REQ-011 tx_ready  input  1  payload transmitter idle/accept.
REQ-012 tx_payload  output  PAYLOAD_W  registered payload held for the whole frame.
REQ-013 tx_src  output  $clog2(N_PORTS+1)  source of current frame; value N_PORTS = heartbeat.
REQ-014 tx_done  output  1  one-cycle pulse when the transmitter returns to ready after a frame.

Function
REQ-015 States IDLE, OFFER, BUSY; the block SHALL register all outputs except req_ready.
REQ-016 IDLE: if any req_valid, grant one port, assert its req_ready combinationally that cycle, latch req_payload into tx_payload and port index into tx_src, go to OFFER.
REQ-017 Grant priority: port 0 strictly highest; ports 1..N_PORTS-1 round-robin, starting search at rr_ptr.
REQ-018 After a grant to port k>=1, rr_ptr SHALL become k+1, wrapping from N_PORTS-1 to 1; a grant to port 0 or a heartbeat leaves rr_ptr unchanged.
REQ-019 IDLE with no req_valid and idle_cnt == HEARTBEAT_TICKS: latch heartbeat_payload, tx_src = N_PORTS, go to OFFER; requests win over heartbeat in the same cycle.
REQ-020 OFFER: tx_valid = 1; on tx_valid & tx_ready go to BUSY with tx_valid = 0 from the next cycle.
REQ-021 BUSY: hold tx_payload and tx_src unchanged; on tx_ready == 1 pulse tx_done for one cycle and go to IDLE.
REQ-022 tx_payload SHALL be stable from the OFFER entry through the last BUSY cycle; the transmitter samples it bytewise, unlatched.
REQ-023 Minimum spacing: a new grant SHALL NOT occur in the cycle tx_done is asserted; earliest next grant is the following cycle.
REQ-024 idle_cnt: counts output_tick while in IDLE, saturates at HEARTBEAT_TICKS, clears to 0 on every transition into OFFER.
REQ-025 A requester dropping req_valid before req_ready SHALL be allowed; no grant is issued to it.
REQ-026 req_ready SHALL be 0 in OFFER and BUSY regardless of req_valid.
REQ-027 tx_ready seen high in BUSY on the first BUSY cycle SHALL be treated as frame complete (no extra guard).

Reset
REQ-028 On reset: state IDLE, tx_valid 0, tx_done 0, tx_payload 0, tx_src 0, rr_ptr 1, idle_cnt 0, req_ready 0.
REQ-029 Reset during OFFER or BUSY SHALL abandon the frame without tx_done; the captured request is not re-issued.

Structure
REQ-030 State enum, source-id type and heartbeat source constant SHALL live in the shared data-frames package beside payload_t.
REQ-031 Round-robin selection SHALL be one sub-module rr_arbiter (request vector, pointer in, one-hot grant out, combinational).

Verification
REQ-032 Port 1 and 2 valid continuously, port 0 idle -> grants alternate 1,2,1,2 over four frames; tx_src matches.
REQ-033 Ports 0 and 2 valid in same IDLE cycle -> port 0 granted, port 2 granted on the next frame; rr_ptr unchanged after port-0 grant.
REQ-034 No requests, HEARTBEAT_TICKS=8, tick every 4 clk -> heartbeat offered after 8th tick, tx_src=3, tx_payload=heartbeat_payload.
REQ-035 Transmitter model holds tx_ready low 20 cycles after accept, req_payload changed meanwhile -> tx_payload constant, tx_done one cycle when tx_ready rises.
REQ-036 Reset asserted in BUSY -> next cycle all outputs at reset values, no tx_done, rr_ptr=1.
REQ-037 Port 1 valid on the cycle idle_cnt reaches 8 -> port 1 granted, idle_cnt cleared, no heartbeat.
